i2c_core_fifo: RTL and testbench
================================

# i2c_core_fifo

Parametrised successor to the single-bus I2C core wrapper. It arbitrates one I2C master engine and one I2C slave engine onto one of `NUM_BUS` pad pairs. Master/slave/off mode and bus changes are applied only at safe points: both engines idle and the target bus free. TX and RX data are buffered in FIFOs between the APB register block and the active engine, which decouples software timing from bus timing.

## Interface
Parameters:
- `DATA_W`, 8, data byte width.
- `FIFO_DEPTH`, 8, entries per FIFO, power of two, ≥2.
- `NUM_BUS`, 2, number of pad pairs, ≥1; `BW = max(1,$clog2(NUM_BUS))`.
- `BUS_FREE_CYC`, 16, consecutive SCL=SDA=1 cycles that define a free bus.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `mode_req` in 2: 01 slave, 10 master, 00/11 off.
- `bus_sel` in BW: requested pad pair.
- `tx_wr_en` / `tx_wr_data` in 1 / DATA_W: APB push to TX FIFO.
- `tx_full` out 1: TX FIFO cannot accept.
- `rx_rd_en` in 1 / `rx_rd_data` out DATA_W: APB pop, show-ahead head.
- `rx_empty` out 1: RX FIFO empty.
- `status_clr` in 1: clears sticky flags.
- `status` out 8: {switching, rx_ovf, tx_udf, tx_full, rx_empty, active_bus_valid, active_mode[1:0]}.
- `m_en`, `s_en` out 1: engine enables.
- `m_busy`, `s_busy` in 1: engine transfer in progress.
- `eng_tx_valid` out 1 / `eng_tx_data` out DATA_W / `eng_tx_pop` in 1: TX FIFO to the active engine.
- `eng_rx_push` in 1 / `eng_rx_data` in DATA_W: active engine to RX FIFO.
- `m_sda_o`, `m_scl_o`, `s_sda_o`, `s_scl_o` in 1: engine pad drive.
- `m_sda_i`, `m_scl_i`, `s_sda_i`, `s_scl_i` out 1: engine pad sense.
- `sda_i`, `scl_i` in NUM_BUS / `sda_o`, `scl_o` out NUM_BUS: pads, 1 = released.

## Operation
- Mode FSM states:
  - S_OFF: active_mode=00.
  - S_RUN: active mode applied.
  - S_WAIT: change pending, old routing kept.
  - S_FLUSH: one cycle; both FIFOs and sticky flags cleared, `active_mode`/`active_bus` loaded from the request.
- S_OFF/S_RUN → S_WAIT when {effective mode_req, bus_sel} differs from {active_mode, active_bus}.
- S_WAIT → S_FLUSH when `!m_busy && !s_busy && free_cnt==BUS_FREE_CYC`.
- S_WAIT → back to the prior state, with no flush, if the request reverts to the active setting.
- S_FLUSH → S_RUN if the new mode is not off, else S_OFF.
- `free_cnt`: counts while `scl_i[bus_sel]&sda_i[bus_sel]`, saturates at BUS_FREE_CYC, clears to 0 otherwise. Width `$clog2(BUS_FREE_CYC+1)`.
- Routing (combinational from registered `active_*`):
  - Master mode: pad[active_bus] ← m_*_o and m_*_i ← pad.
  - Slave mode: the same using s_*.
  - Unused engine inputs are tied to 1; non-active pads and all pads in off mode drive 1.
- `m_en` = master mode & (S_RUN|S_WAIT); `s_en` likewise for slave.
- TX FIFO:
  - Push accepted when `tx_wr_en & !tx_full`.
  - `tx_full` is forced to 1 in S_WAIT/S_FLUSH, and writes are then dropped.
  - `eng_tx_valid = !empty`. A pop while empty is ignored and sets sticky `tx_udf`.
- RX FIFO:
  - Push on `eng_rx_push`. If full and not popping the same cycle, the data is dropped and sticky `rx_ovf` is set.
  - A simultaneous push and pop when full is accepted.
  - `rx_rd_en` while empty is ignored.
- Counts are `$clog2(FIFO_DEPTH+1)` bits; pointers wrap modulo FIFO_DEPTH.
- `status_clr` clears the sticky flags; a set event in the same cycle wins.
- `bus_sel ≥ NUM_BUS` is treated as mode off.

## Timing
- Reset state (async assert, synchronous deassert):
  - FSM in S_OFF; `active_mode=00`, `active_bus=0`; FIFOs empty; flags 0; `free_cnt=0`.
  - Outputs: `sda_o`/`scl_o` all 1, `m_en`/`s_en` 0, `tx_full` 0, `rx_empty` 1, `status=8'h08`.
- Reset mid-transfer: pads are released immediately (asynchronously).
- FIFO push → visible at head and flags the next cycle. Pop → next head the next cycle.
- Mode change with engines idle and bus already free:
  - request at cycle n, S_WAIT at n+1, S_FLUSH at n+2, new routing effective at n+3.
- `status[7]` (switching) = 1 in S_WAIT and S_FLUSH.

## Structure
- Shared package `i2c_pkg` holds:
  - mode constants MODE_OFF=2'b00, MODE_SLAVE=2'b01, MODE_MASTER=2'b10;
  - FSM state enum;
  - status bit index constants.
- Sub-module `i2c_sync_fifo` (DATA_W, DEPTH; push, pop, flush, full, empty, count, head) is instantiated twice.
- The mode FSM, free counter and pad mux live in the top module.

## Test plan
- Reset, then idle: all pads 1, `status=8'h08`, `m_en=s_en=0`.
- `mode_req=10`, `bus_sel=1`, pads idle: `m_en=1` at cycle n+3 after the free count is reached; `scl_o[1]` follows `m_scl_o`; `scl_o[0]=1`.
- Push 0xA5, 0x3C with master active: `eng_tx_data=0xA5`, then 0x3C after one `eng_tx_pop`. A 9th push at DEPTH=8 is rejected with `tx_full=1`.
- Request slave while `m_busy=1` for 50 cycles: status bit 7 = 1 throughout and master routing held. Switch occurs BUS_FREE_CYC+2 cycles after `m_busy` falls with the bus idle. FIFOs are empty afterwards.
- Fill the RX FIFO with 8 pushes, then push 0x77: `rx_ovf=1` and 0x77 is absent. Push with a same-cycle pop when full: accepted, no overflow. `status_clr` clears `rx_ovf`.
- Assert `rst` mid-transfer: pads go to 1 the same cycle and all state returns to reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the multi-bus I2C core: mode encodings, mode FSM states,
// status bit positions and the request-qualification helper.
package i2c_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_SLAVE  = 2'b01;
    localparam logic [1:0] MODE_MASTER = 2'b10;

    typedef enum logic [1:0] {
        S_OFF,
        S_RUN,
        S_WAIT,
        S_FLUSH
    } state_t;

    localparam int ST_MODE_LSB  = 0;
    localparam int ST_BUS_VALID = 2;
    localparam int ST_RX_EMPTY  = 3;
    localparam int ST_TX_FULL   = 4;
    localparam int ST_TX_UDF    = 5;
    localparam int ST_RX_OVF    = 6;
    localparam int ST_SWITCHING = 7;

    // 2'b11 and any out-of-range bus both collapse to off.
    function automatic logic [1:0] eff_mode(input logic [1:0] req, input logic bus_ok);
        return (bus_ok && (req == MODE_SLAVE || req == MODE_MASTER)) ? req : MODE_OFF;
    endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock show-ahead FIFO; push/pop are self-guarded against full/empty,
// and a simultaneous push and pop on a full FIFO is accepted.
module i2c_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/i2c_core_fifo.sv
// Arbitrates one master and one slave I2C engine onto one of NUM_BUS pad pairs,
// switching only when both engines are idle and the target bus has been free.
module i2c_core_fifo
    import i2c_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int NUM_BUS      = 2,
    parameter int BUS_FREE_CYC = 16,
    localparam int BW          = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode_req,
    input  logic [BW-1:0]      bus_sel,
    input  logic               tx_wr_en,
    input  logic [DATA_W-1:0]  tx_wr_data,
    output logic               tx_full,
    input  logic               rx_rd_en,
    output logic [DATA_W-1:0]  rx_rd_data,
    output logic               rx_empty,
    input  logic               status_clr,
    output logic [7:0]         status,
    output logic               m_en,
    output logic               s_en,
    input  logic               m_busy,
    input  logic               s_busy,
    output logic               eng_tx_valid,
    output logic [DATA_W-1:0]  eng_tx_data,
    input  logic               eng_tx_pop,
    input  logic               eng_rx_push,
    input  logic [DATA_W-1:0]  eng_rx_data,
    input  logic               m_sda_o,
    input  logic               m_scl_o,
    input  logic               s_sda_o,
    input  logic               s_scl_o,
    output logic               m_sda_i,
    output logic               m_scl_i,
    output logic               s_sda_i,
    output logic               s_scl_i,
    input  logic [NUM_BUS-1:0] sda_i,
    input  logic [NUM_BUS-1:0] scl_i,
    output logic [NUM_BUS-1:0] sda_o,
    output logic [NUM_BUS-1:0] scl_o
);

    localparam int FW = $clog2(BUS_FREE_CYC + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t        state;
    logic [1:0]    active_mode;
    logic [BW-1:0] active_bus;
    logic [FW-1:0] free_cnt;
    logic          bus_ok;
    logic          sel_idle;
    logic [1:0]    req_mode;
    logic          req_differs;
    logic          flush;
    logic          switching;
    logic          tx_udf;
    logic          rx_ovf;
    logic          tx_fifo_full;
    logic          tx_empty;
    logic          rx_full;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;

    // An out-of-range bus_sel reads as idle so a request to it can settle into off.
    always_comb begin
        bus_ok   = 1'b0;
        sel_idle = 1'b1;
        for (int b = 0; b < NUM_BUS; b++) begin
            if (BW'(b) == bus_sel) begin
                bus_ok   = 1'b1;
                sel_idle = scl_i[b] & sda_i[b];
            end
        end
    end

    assign req_mode    = eff_mode(mode_req, bus_ok);
    assign req_differs = (req_mode != active_mode) || (bus_sel != active_bus);
    assign flush       = (state == S_FLUSH);
    assign switching   = (state == S_WAIT) || (state == S_FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_cnt <= '0;
        end else if (!sel_idle) begin
            free_cnt <= '0;
        end else if (free_cnt != FW'(BUS_FREE_CYC)) begin
            free_cnt <= free_cnt + FW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_OFF;
            active_mode <= MODE_OFF;
            active_bus  <= '0;
            m_en        <= 1'b0;
            s_en        <= 1'b0;
        end else begin
            case (state)
                S_OFF, S_RUN: begin
                    if (req_differs) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!req_differs)
                        state <= (active_mode == MODE_OFF) ? S_OFF : S_RUN;
                    else if (!m_busy && !s_busy && free_cnt == FW'(BUS_FREE_CYC))
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    active_mode <= req_mode;
                    active_bus  <= bus_sel;
                    m_en        <= (req_mode == MODE_MASTER);
                    s_en        <= (req_mode == MODE_SLAVE);
                    state       <= (req_mode == MODE_OFF) ? S_OFF : S_RUN;
                end
                default: state <= S_OFF;
            endcase
        end
    end

    // Pad mux follows only the registered active_* so routing never glitches on requests.
    always_comb begin
        sda_o   = '1;
        scl_o   = '1;
        m_sda_i = 1'b1;
        m_scl_i = 1'b1;
        s_sda_i = 1'b1;
        s_scl_i = 1'b1;
        for (int b = 0; b < NUM_BUS; b++) begin
            if (BW'(b) == active_bus) begin
                if (active_mode == MODE_MASTER) begin
                    sda_o[b] = m_sda_o;
                    scl_o[b] = m_scl_o;
                    m_sda_i  = sda_i[b];
                    m_scl_i  = scl_i[b];
                end else if (active_mode == MODE_SLAVE) begin
                    sda_o[b] = s_sda_o;
                    scl_o[b] = s_scl_o;
                    s_sda_i  = sda_i[b];
                    s_scl_i  = scl_i[b];
                end
            end
        end
    end

    // Engine TX handshake: eng_tx_data is valid while eng_tx_valid is high and holds
    // until the engine pulses eng_tx_pop; a pop with valid low is an underflow.
    assign tx_full      = tx_fifo_full | switching;
    assign eng_tx_valid = ~tx_empty;

    i2c_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_wr_en & ~tx_full),
        .push_data (tx_wr_data),
        .pop       (eng_tx_pop),
        .flush     (flush),
        .full      (tx_fifo_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .head      (eng_tx_data)
    );

    i2c_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (eng_rx_push),
        .push_data (eng_rx_data),
        .pop       (rx_rd_en),
        .flush     (flush),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count),
        .head      (rx_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_udf <= 1'b0;
            rx_ovf <= 1'b0;
        end else if (flush) begin
            tx_udf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (eng_tx_pop && tx_empty)               tx_udf <= 1'b1;
            else if (status_clr)                      tx_udf <= 1'b0;
            if (eng_rx_push && rx_full && !rx_rd_en)  rx_ovf <= 1'b1;
            else if (status_clr)                      rx_ovf <= 1'b0;
        end
    end

    assign status = {switching, rx_ovf, tx_udf, tx_full, rx_empty,
                     (active_mode != MODE_OFF), active_mode};

    fifo_count_ok: assert property (@(posedge clk) disable iff (rst)
        (tx_count <= CW'(FIFO_DEPTH)) && (rx_count <= CW'(FIFO_DEPTH)) &&
        (tx_empty == (tx_count == '0)) && (rx_empty == (rx_count == '0)));

endmodule

// File: tb/tb_i2c_core_fifo.sv
// Directed bench for i2c_core_fifo: mode switching, pad routing, FIFO flow control,
// sticky flags and asynchronous reset, with hand-computed expectations.
module tb_i2c_core_fifo;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int NUM_BUS = 2;
    localparam int FREE    = 16;
    localparam int BW      = 1;

    logic               clk;
    logic               rst;
    logic [1:0]         mode_req;
    logic [BW-1:0]      bus_sel;
    logic               tx_wr_en;
    logic [DATA_W-1:0]  tx_wr_data;
    logic               tx_full;
    logic               rx_rd_en;
    logic [DATA_W-1:0]  rx_rd_data;
    logic               rx_empty;
    logic               status_clr;
    logic [7:0]         status;
    logic               m_en, s_en, m_busy, s_busy;
    logic               eng_tx_valid;
    logic [DATA_W-1:0]  eng_tx_data;
    logic               eng_tx_pop;
    logic               eng_rx_push;
    logic [DATA_W-1:0]  eng_rx_data;
    logic               m_sda_o, m_scl_o, s_sda_o, s_scl_o;
    logic               m_sda_i, m_scl_i, s_sda_i, s_scl_i;
    logic [NUM_BUS-1:0] sda_i, scl_i, sda_o, scl_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_d;
    int n_wait;

    i2c_core_fifo #(
        .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .NUM_BUS(NUM_BUS), .BUS_FREE_CYC(FREE)
    ) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req), .bus_sel(bus_sel),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty),
        .status_clr(status_clr), .status(status), .m_en(m_en), .s_en(s_en),
        .m_busy(m_busy), .s_busy(s_busy), .eng_tx_valid(eng_tx_valid),
        .eng_tx_data(eng_tx_data), .eng_tx_pop(eng_tx_pop),
        .eng_rx_push(eng_rx_push), .eng_rx_data(eng_rx_data),
        .m_sda_o(m_sda_o), .m_scl_o(m_scl_o), .s_sda_o(s_sda_o), .s_scl_o(s_scl_o),
        .m_sda_i(m_sda_i), .m_scl_i(m_scl_i), .s_sda_i(s_sda_i), .s_scl_i(s_scl_i),
        .sda_i(sda_i), .scl_i(scl_i), .sda_o(sda_o), .scl_o(scl_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [DATA_W-1:0] d);
        tx_wr_en   = 1'b1;
        tx_wr_data = d;
        tick();
        tx_wr_en   = 1'b0;
    endtask

    task automatic pop_tx();
        eng_tx_pop = 1'b1;
        tick();
        eng_tx_pop = 1'b0;
    endtask

    task automatic push_rx(input logic [DATA_W-1:0] d, input logic rd);
        eng_rx_push = 1'b1;
        eng_rx_data = d;
        rx_rd_en    = rd;
        tick();
        eng_rx_push = 1'b0;
        rx_rd_en    = 1'b0;
    endtask

    task automatic clr_status();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode_req = 2'b00; bus_sel = '0;
        tx_wr_en = 0; tx_wr_data = '0; rx_rd_en = 0; status_clr = 0;
        m_busy = 0; s_busy = 0; eng_tx_pop = 0; eng_rx_push = 0; eng_rx_data = '0;
        m_sda_o = 1; m_scl_o = 1; s_sda_o = 1; s_scl_o = 1;
        sda_i = '1; scl_i = '1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_status", status, 8'h08);
        check("rst_sda_o", sda_o, 2'b11);
        check("rst_scl_o", scl_o, 2'b11);
        check("rst_m_en", m_en, 0);
        check("rst_s_en", s_en, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_valid", eng_tx_valid, 0);
        check("rst_m_scl_i", m_scl_i, 1);

        // mode 11 is off: matches the active setting, no switch
        mode_req = 2'b11;
        tick(); tick();
        check("mode11_no_switch", status[7], 0);
        mode_req = 2'b00;
        repeat (20) tick();

        // Master on bus 1, bus already free: WAIT, FLUSH, then RUN
        mode_req = 2'b10; bus_sel = 1'b1;
        tick();
        check("sw_wait_flag", status[7], 1);
        check("sw_wait_m_en", m_en, 0);
        tick();
        check("sw_flush_flag", status[7], 1);
        check("sw_flush_m_en", m_en, 0);
        tick();
        check("sw_run_m_en", m_en, 1);
        check("sw_run_status", status, 8'h0E);
        m_scl_o = 0; m_sda_o = 0; #1;
        check("m_route_scl", scl_o, 2'b01);
        check("m_route_sda", sda_o, 2'b01);
        m_scl_o = 1; m_sda_o = 1;
        scl_i = 2'b01; #1;
        check("m_sense_scl", m_scl_i, 0);
        check("s_sense_tied", s_scl_i, 1);
        scl_i = 2'b11;

        // TX FIFO ordering and underflow
        push_tx(8'hA5);
        check("tx_valid", eng_tx_valid, 1);
        check("tx_head0", eng_tx_data, 8'hA5);
        push_tx(8'h3C);
        check("tx_head_hold", eng_tx_data, 8'hA5);
        pop_tx();
        check("tx_head1", eng_tx_data, 8'h3C);
        pop_tx();
        check("tx_empty", eng_tx_valid, 0);
        pop_tx();
        check("tx_udf_set", status[5], 1);
        clr_status();
        check("tx_udf_clr", status[5], 0);

        // TX fill to depth, ninth push rejected
        for (int i = 0; i < DEPTH; i++) begin
            push_tx(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        check("tx_full_set", tx_full, 1);
        push_tx(8'hEE);
        for (int i = 0; i < DEPTH; i++) begin
            exp_d = exp_q.pop_front();
            check("tx_drain", eng_tx_data, 32'(exp_d));
            pop_tx();
        end
        check("tx_drained", eng_tx_valid, 0);

        // RX fill, overflow, clear, push+pop when full
        for (int i = 0; i < DEPTH; i++) begin
            push_rx(8'h40 + 8'(i), 1'b0);
            exp_q.push_back(8'h40 + 8'(i));
        end
        check("rx_nonempty", rx_empty, 0);
        check("rx_head", rx_rd_data, 8'h40);
        push_rx(8'h77, 1'b0);
        check("rx_ovf_set", status[6], 1);
        clr_status();
        check("rx_ovf_clr", status[6], 0);
        push_rx(8'h88, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h88);
        check("rx_pushpop_no_ovf", status[6], 0);
        for (int i = 0; i < DEPTH; i++) begin
            exp_d = exp_q.pop_front();
            check("rx_drain", rx_rd_data, 32'(exp_d));
            rx_rd_en = 1'b1; tick(); rx_rd_en = 1'b0;
        end
        check("rx_drained", rx_empty, 1);
        rx_rd_en = 1'b1; tick(); rx_rd_en = 1'b0;
        check("rx_pop_empty", rx_empty, 1);

        // Request reverts while waiting: no flush
        push_tx(8'h5A);
        m_busy = 1'b1; mode_req = 2'b01;
        tick();
        check("revert_wait", status[7], 1);
        mode_req = 2'b10;
        tick();
        check("revert_run", status[7], 0);
        check("revert_keep_tx", eng_tx_data, 8'h5A);

        // Slave request while master busy: held for 50 cycles
        push_rx(8'h99, 1'b0);
        scl_i = 2'b01; mode_req = 2'b01;
        for (int i = 0; i < 50; i++) begin
            m_scl_o = 1'(i);
            tick();
            check("busy_switching", status[7], 1);
            check("busy_m_en", m_en, 1);
            check("busy_m_route", scl_o[1], m_scl_o);
        end
        check("busy_tx_full", tx_full, 1);
        m_busy = 1'b0; scl_i = 2'b11; m_scl_o = 1'b1;
        n_wait = 0;
        while (!s_en && n_wait < 100) begin
            tick();
            n_wait++;
        end
        check("switch_latency", n_wait, FREE + 2);
        check("slave_status", status, 8'h0D);
        check("slave_m_en", m_en, 0);
        check("flushed_tx", eng_tx_valid, 0);
        check("flushed_rx", rx_empty, 1);
        s_scl_o = 1'b0; #1;
        check("s_route_scl", scl_o, 2'b01);
        check("m_sense_tied", m_scl_i, 1);

        // Asynchronous reset mid-cycle releases the pads at once
        #2;
        rst = 1'b1;
        #1;
        check("arst_scl_o", scl_o, 2'b11);
        check("arst_sda_o", sda_o, 2'b11);
        check("arst_s_en", s_en, 0);
        check("arst_status", status, 8'h08);
        s_scl_o = 1'b1;
        tick();
        rst = 1'b0;
        mode_req = 2'b00; bus_sel = '0;
        tick();
        check("post_rst_status", status, 8'h08);
        check("post_rst_tx_full", tx_full, 0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
